axi3_burst_master: RTL and testbench

- Parametrised AXI3 master engine that replaces a bare CPU-side AXI port.
- Accepts single-burst read/write commands on a valid/ready command port.
- Drives the full AR/R/AW/W/B channel set with INCR bursts of 1–16 beats.
- Streams write data in, streams read data out, and reports a per-command completion status.
- One transaction is outstanding at a time. It sits where a processor or test master would attach to the SRAM bridge.

---
 rtl/axi3_burst_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi3_burst_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_burst_master.sv
// axi3_burst_master
//   Single-outstanding AXI3 master engine. Takes one burst command at a time
//   on a valid/ready port, issues an INCR burst of 1-16 beats on AR/R or
//   AW/W/B, streams write data in and read data out, and pulses a completion
//   status with the worst response seen during the command.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   cmd_*                       command handshake: write flag, start address,
//                               len (beats-1), size (log2 bytes per beat)
//   wd_*                        write-data stream into the engine
//   rd_*                        read-data stream out of the engine
//   done_valid, done_resp       one-cycle completion pulse with worst response
//   ar*, r*, aw*, w*, b*        AXI3 read and write channels
module axi3_burst_master #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_VAL = 0
) (
  input  logic                clk,
  input  logic                resetn,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  // write-data stream
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  // read-data stream
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  // completion
  output logic                done_valid,
  output logic [1:0]          done_resp,
  // AXI3 read address
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  // AXI3 read data
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI3 write address
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  // AXI3 write data
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI3 write response
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int unsigned     STRB_W   = DATA_W / 8;
  localparam logic [2:0]      MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [ID_W-1:0] ID       = ID_W'(ID_VAL);
  localparam logic [1:0]      SLVERR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RD,
    S_AW,
    S_WD,
    S_WB,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic [4:0]        cnt_q;
  logic [1:0]        resp_q;
  logic              cmd_ready_q;

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Command screening: byte span of the burst against the 4KB page, and a
  // beat size wider than the data bus.
  logic [13:0] span;
  logic [13:0] end_addr;
  logic        cmd_bad;

  always_comb begin
    span     = 14'({1'b0, cmd_len} + 5'd1) << cmd_size;
    end_addr = {2'b00, cmd_addr[11:0]} + span;
    cmd_bad  = (end_addr > 14'd4096) || (cmd_size > MAX_SIZE);
  end

  // Response merging for the beat being accepted this cycle.
  logic [1:0] r_resp_d;
  logic [1:0] b_resp_d;
  logic [4:0] cnt_d;
  logic       len_hit;

  always_comb begin
    len_hit  = (cnt_q == {1'b0, len_q});
    r_resp_d = worst(resp_q, rresp);
    if (rid != ID) r_resp_d = worst(r_resp_d, SLVERR);
    // rlast arriving early or late means the slave miscounted the burst
    if (rlast && !len_hit) r_resp_d = worst(r_resp_d, SLVERR);
    b_resp_d = worst(resp_q, bresp);
    if (bid != ID) b_resp_d = worst(b_resp_d, SLVERR);
    // saturate so a runaway read burst cannot fold back onto len
    cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
  end

  // Channel outputs decoded from the state register; R and W data paths are
  // zero-latency pass-throughs gated by the state.
  assign cmd_ready  = cmd_ready_q;

  assign arid       = ID;
  assign araddr     = addr_q;
  assign arlen      = len_q;
  assign arsize     = size_q;
  assign arburst    = 2'b01;
  assign arlock     = '0;
  assign arcache    = '0;
  assign arprot     = '0;
  assign arvalid    = (state_q == S_AR);

  assign rready     = (state_q == S_RD) && rd_ready;
  assign rd_valid   = (state_q == S_RD) && rvalid;
  assign rd_data    = rdata;
  assign rd_last    = (state_q == S_RD) && rlast;

  assign awid       = ID;
  assign awaddr     = addr_q;
  assign awlen      = len_q;
  assign awsize     = size_q;
  assign awburst    = 2'b01;
  assign awlock     = '0;
  assign awcache    = '0;
  assign awprot     = '0;
  assign awvalid    = (state_q == S_AW);

  assign wid        = ID;
  assign wdata      = wd_data;
  assign wstrb      = wd_strb;
  assign wvalid     = (state_q == S_WD) && wd_valid;
  assign wd_ready   = (state_q == S_WD) && wready;
  assign wlast      = (state_q == S_WD) && len_hit;

  assign bready     = (state_q == S_WB);

  assign done_valid = (state_q == S_DONE);
  assign done_resp  = (state_q == S_DONE) ? resp_q : '0;

  // cmd_ready is registered so that it stays low during reset and in DONE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            size_q      <= cmd_size;
            cmd_ready_q <= 1'b0;
            if (cmd_bad) begin
              resp_q  <= SLVERR;
              state_q <= S_DONE;
            end else begin
              state_q <= cmd_write ? S_AW : S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) state_q <= S_RD;
        end
        S_RD: begin
          if (rvalid && rd_ready) begin
            cnt_q  <= cnt_d;
            resp_q <= r_resp_d;
            if (rlast) state_q <= S_DONE;
          end
        end
        S_AW: begin
          if (awready) state_q <= S_WD;
        end
        S_WD: begin
          if (wd_valid && wready) begin
            cnt_q <= cnt_d;
            if (len_hit) state_q <= S_WB;
          end
        end
        S_WB: begin
          if (bvalid) begin
            resp_q  <= b_resp_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_q       <= '0;
          resp_q      <= '0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi3_burst_master.sv
// Directed bench for axi3_burst_master: reads, writes, 4KB/size rejection,
// response merging, protocol faults and mid-burst reset.
module tb_axi3_burst_master;

  logic        clk;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;

  axi3_burst_master #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .ID_VAL(0)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] l,
                       input logic [2:0] s);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ar_hs();
    chk("arvalid", 64'(arvalid), 64'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("arvalid_drop", 64'(arvalid), 64'd0);
  endtask

  task automatic aw_hs();
    chk("awvalid", 64'(awvalid), 64'd1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
  endtask

  task automatic rbeat(input logic [31:0] d, input logic [1:0] rs, input logic [3:0] id,
                       input logic last);
    rvalid = 1'b1; rdata = d; rresp = rs; rid = id; rlast = last;
    #1;
    chk("rd_valid", 64'(rd_valid), 64'd1);
    chk("rready", 64'(rready), 64'd1);
    chk("rd_data", 64'(rd_data), 64'(d));
    chk("rd_last", 64'(rd_last), 64'(last));
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic exp_last);
    wd_valid = 1'b1; wready = 1'b1; wd_data = d;
    #1;
    chk("wvalid", 64'(wvalid), 64'd1);
    chk("wdata", 64'(wdata), 64'(d));
    chk("wlast", 64'(wlast), 64'(exp_last));
    tick();
    wd_valid = 1'b0; wready = 1'b0;
  endtask

  task automatic bbeat(input logic [1:0] rs, input logic [3:0] id);
    chk("bready", 64'(bready), 64'd1);
    bvalid = 1'b1; bresp = rs; bid = id;
    tick();
    bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
  endtask

  task automatic done_chk(input logic [1:0] exp);
    chk("done_valid", 64'(done_valid), 64'd1);
    chk("done_resp", 64'(done_resp), 64'(exp));
    chk("cmd_ready_done", 64'(cmd_ready), 64'd0);
    tick();
    chk("done_pulse", 64'(done_valid), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; wd_valid = 1'b0; wd_data = '0; wd_strb = 4'hF; rd_ready = 1'b1;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_done_resp", 64'(done_resp), 64'd0);
    resetn = 1'b1;
    tick();

    // 1: read 0x100 len 3 size 2
    issue(1'b0, 32'h100, 4'd3, 3'd2);
    chk("t1_araddr", 64'(araddr), 64'h100);
    chk("t1_arlen", 64'(arlen), 64'd3);
    chk("t1_arsize", 64'(arsize), 64'd2);
    chk("t1_arburst", 64'(arburst), 64'd1);
    chk("t1_arid", 64'(arid), 64'd0);
    chk("t1_arcache", 64'({arlock, arcache, arprot}), 64'd0);
    ar_hs();
    for (int unsigned i = 0; i < 4; i++)
      rbeat(32'hA0 + i, 2'b00, 4'd0, i == 3);
    done_chk(2'b00);

    // 2: write 0x200 len 1, awready held off 3 cycles, wready toggling
    issue(1'b1, 32'h200, 4'd1, 3'd2);
    chk("t2_awaddr", 64'(awaddr), 64'h200);
    chk("t2_awlen", 64'(awlen), 64'd1);
    chk("t2_awburst", 64'(awburst), 64'd1);
    wd_valid = 1'b1; wready = 1'b1; wd_data = 32'h11;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk("t2_aw_hold", 64'(awvalid), 64'd1);
      chk("t2_w_early", 64'(wvalid), 64'd0);
      chk("t2_wd_early", 64'(wd_ready), 64'd0);
      tick();
    end
    aw_hs();
    wready = 1'b0;
    #1;
    chk("t2_wvalid", 64'(wvalid), 64'd1);
    chk("t2_wd_ready_lo", 64'(wd_ready), 64'd0);
    chk("t2_wlast0", 64'(wlast), 64'd0);
    tick();
    wready = 1'b1;
    #1;
    chk("t2_wdata0", 64'(wdata), 64'h11);
    chk("t2_wlast0b", 64'(wlast), 64'd0);
    chk("t2_wd_ready_hi", 64'(wd_ready), 64'd1);
    chk("t2_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    wready = 1'b0; wd_data = 32'h22;
    #1;
    chk("t2_wdata1", 64'(wdata), 64'h22);
    chk("t2_wlast1", 64'(wlast), 64'd1);
    tick();
    wready = 1'b1;
    #1;
    chk("t2_wlast1b", 64'(wlast), 64'd1);
    tick();
    wd_valid = 1'b0; wready = 1'b0;
    chk("t2_wvalid_off", 64'(wvalid), 64'd0);
    bbeat(2'b00, 4'd0);
    done_chk(2'b00);

    // 3: 4KB crossing 0xFF8 + 16 bytes -> rejected, no AR
    issue(1'b0, 32'hFF8, 4'd3, 3'd2);
    chk("t3_no_ar", 64'(arvalid), 64'd0);
    done_chk(2'b10);
    chk("t3_no_ar_after", 64'(arvalid), 64'd0);
    // ends exactly on the page boundary -> allowed
    issue(1'b0, 32'hFFC, 4'd0, 3'd2);
    ar_hs();
    rbeat(32'h5A5A, 2'b00, 4'd0, 1'b1);
    done_chk(2'b00);
    // beat size wider than the 32-bit bus -> rejected
    issue(1'b1, 32'h0, 4'd0, 3'd3);
    chk("t3_size_no_aw", 64'(awvalid), 64'd0);
    done_chk(2'b10);

    // 4: response merge
    issue(1'b0, 32'h300, 4'd2, 3'd2);
    ar_hs();
    rbeat(32'h1, 2'b00, 4'd0, 1'b0);
    rbeat(32'h2, 2'b10, 4'd0, 1'b0);
    rbeat(32'h3, 2'b00, 4'd0, 1'b1);
    done_chk(2'b10);
    issue(1'b1, 32'h400, 4'd0, 3'd2);
    aw_hs();
    wbeat(32'h33, 1'b1);
    bbeat(2'b11, 4'd0);
    done_chk(2'b11);

    // 5: protocol faults
    issue(1'b0, 32'h500, 4'd3, 3'd2);
    ar_hs();
    rbeat(32'h7, 2'b00, 4'd0, 1'b0);
    rbeat(32'h8, 2'b00, 4'd0, 1'b1);
    done_chk(2'b10);
    issue(1'b1, 32'h600, 4'd0, 3'd2);
    aw_hs();
    wbeat(32'h44, 1'b1);
    bbeat(2'b00, 4'd1);
    done_chk(2'b10);

    // 6: reset mid-read at beat 1
    issue(1'b0, 32'h700, 4'd3, 3'd2);
    ar_hs();
    rbeat(32'hB0, 2'b00, 4'd0, 1'b0);
    rvalid = 1'b1; rdata = 32'hB1;
    resetn = 1'b0;
    tick();
    resetn = 1'b1; rvalid = 1'b0;
    #1;
    chk("t6_arvalid", 64'(arvalid), 64'd0);
    chk("t6_rready", 64'(rready), 64'd0);
    chk("t6_rd_valid", 64'(rd_valid), 64'd0);
    chk("t6_awvalid", 64'(awvalid), 64'd0);
    chk("t6_wvalid", 64'(wvalid), 64'd0);
    chk("t6_bready", 64'(bready), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("t6_done", 64'(done_valid), 64'd0);
    tick();
    issue(1'b0, 32'h800, 4'd1, 3'd2);
    ar_hs();
    rbeat(32'hC0, 2'b00, 4'd0, 1'b0);
    rbeat(32'hC1, 2'b00, 4'd0, 1'b1);
    done_chk(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
